// File: rtl/databus_pkg.sv
// Front-end shared types: exception codes, text-segment bounds and opcode decode.
// Pure declarations plus one combinational helper; no timing or flow control.
package databus;

    typedef enum logic [4:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4
    } exc_code_t;

    localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] TEXT_END   = 32'h0000_6FFC;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [31:0] ERET_INSTR = 32'h4200_0018;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // True for every instruction that owns a delay slot.
    function automatic logic is_branch(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        case (op)
            OP_REGIMM, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
            OP_SPECIAL: is_branch = (fn == FN_JR) || (fn == FN_JALR);
            default:    is_branch = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Word-aligned address window check; purely combinational, zero latency.
// No flow control: the fault flag follows the address every cycle.
module fetch_addr_check
    import databus::*;
#(
    parameter logic [31:0] LO_ADDR = TEXT_BASE,
    parameter logic [31:0] HI_ADDR = TEXT_END
) (
    input  logic [31:0] addr,
    output logic        fault
);

    always_comb begin
        fault = (addr[1:0] != 2'b00) || (addr < LO_ADDR) || (addr > HI_ADDR);
    end

endmodule

// File: rtl/if_id_reg.sv
// IF->ID register with AdEL check, delay-slot tagging and post-ERET squash; 1-cycle latency.
// stall holds every register; Req flushes to a handler bubble and overrides stall.
module if_id_reg
    import databus::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_Instr,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_Instr,
    output logic        ID_Valid,
    output logic        ID_BD,
    output logic [4:0]  ID_ExcCode
);

    logic      fetch_fault;
    logic      eret_in_id;
    logic      bd_next;
    logic      kill_q;
    exc_code_t exc_q;

    fetch_addr_check #(
        .LO_ADDR (TEXT_BASE),
        .HI_ADDR (TEXT_END)
    ) u_fetch_addr_check (
        .addr  (IF_PC),
        .fault (fetch_fault)
    );

    // The fetch sitting in IF while ERET occupies ID is the wrong path: it is
    // squashed as ERET advances, and kill_q marks that ID now holds the squashed slot.
    always_comb begin
        eret_in_id = ID_Valid && (ID_Instr == ERET_INSTR);
        bd_next    = ID_Valid && is_branch(ID_Instr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ID_PC    <= 32'h0;
            ID_Instr <= 32'h0;
            ID_Valid <= 1'b0;
            ID_BD    <= 1'b0;
            exc_q    <= EXC_NONE;
            kill_q   <= 1'b0;
        end else if (Req) begin
            ID_PC    <= HANDLER_PC;
            ID_Instr <= 32'h0;
            ID_Valid <= 1'b0;
            ID_BD    <= 1'b0;
            exc_q    <= EXC_NONE;
            kill_q   <= 1'b0;
        end else if (!stall) begin
            ID_PC  <= IF_PC;
            kill_q <= eret_in_id;
            if (eret_in_id) begin
                ID_Instr <= 32'h0;
                ID_Valid <= 1'b0;
                ID_BD    <= 1'b0;
                exc_q    <= EXC_NONE;
            end else if (fetch_fault) begin
                ID_Instr <= 32'h0;
                ID_Valid <= 1'b1;
                ID_BD    <= bd_next;
                exc_q    <= EXC_ADEL;
            end else begin
                ID_Instr <= IF_Instr;
                ID_Valid <= 1'b1;
                ID_BD    <= bd_next;
                exc_q    <= EXC_NONE;
            end
        end
    end

    assign ID_ExcCode = exc_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboarded random/directed bench for if_id_reg against a slot-level reference model.
module tb_if_id_reg;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam logic [31:0] TEND = 32'h0000_6FFC;
    localparam logic [31:0] HPC  = 32'h0000_4180;
    localparam logic [31:0] ERET = 32'h4200_0018;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        Req = 1'b0;
    logic [31:0] IF_PC = 32'h0;
    logic [31:0] IF_Instr = 32'h0;
    logic [31:0] ID_PC;
    logic [31:0] ID_Instr;
    logic        ID_Valid;
    logic        ID_BD;
    logic [4:0]  ID_ExcCode;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        bd;
        logic [4:0]  exc;
    } slot_t;

    slot_t exp_q[$];
    slot_t m;
    int checks = 0;
    int errors = 0;

    if_id_reg dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .Req        (Req),
        .IF_PC      (IF_PC),
        .IF_Instr   (IF_Instr),
        .ID_PC      (ID_PC),
        .ID_Instr   (ID_Instr),
        .ID_Valid   (ID_Valid),
        .ID_BD      (ID_BD),
        .ID_ExcCode (ID_ExcCode)
    );

    always #5 clk = ~clk;

    function automatic bit has_delay_slot(input logic [31:0] w);
        int op;
        int fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
    endfunction

    function automatic bit bad_fetch(input logic [31:0] a);
        return (a % 4 != 0) || (a < BASE) || (a > TEND);
    endfunction

    // One clock of stimulus: drive at the falling edge and predict the slot.
    task automatic step(input bit st, input bit rq, input logic [31:0] pc, input logic [31:0] ins);
        slot_t n;
        @(negedge clk);
        stall = st;
        Req = rq;
        IF_PC = pc;
        IF_Instr = ins;
        n = m;
        if (rq) begin
            n = '{HPC, 32'h0, 1'b0, 1'b0, 5'd0};
        end else if (!st) begin
            n.pc = pc;
            if (m.valid && m.instr == ERET)
                n = '{pc, 32'h0, 1'b0, 1'b0, 5'd0};
            else if (bad_fetch(pc))
                n = '{pc, 32'h0, 1'b1, m.valid && has_delay_slot(m.instr), 5'd4};
            else
                n = '{pc, ins, 1'b1, m.valid && has_delay_slot(m.instr), 5'd0};
        end
        m = n;
        exp_q.push_back(n);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (ID_PC !== 32'h0 || ID_Instr !== 32'h0 || ID_Valid !== 1'b0 ||
            ID_BD !== 1'b0 || ID_ExcCode !== 5'd0) begin
            errors++;
            $display("FAIL %s got pc=%h instr=%h v=%b bd=%b exc=%0d want all zero",
                     name, ID_PC, ID_Instr, ID_Valid, ID_BD, ID_ExcCode);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare 1ns after each edge.
    initial begin
        slot_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ID_PC !== e.pc || ID_Instr !== e.instr || ID_Valid !== e.valid ||
                    ID_BD !== e.bd || ID_ExcCode !== e.exc) begin
                    errors++;
                    $display("FAIL slot@%0t got pc=%h instr=%h v=%b bd=%b exc=%0d want pc=%h instr=%h v=%b bd=%b exc=%0d",
                             $time, ID_PC, ID_Instr, ID_Valid, ID_BD, ID_ExcCode,
                             e.pc, e.instr, e.valid, e.bd, e.exc);
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] edges [4];
        int waited;

        edges[0] = 32'h0000_2FFC;
        edges[1] = 32'h0000_3000;
        edges[2] = 32'h0000_6FFC;
        edges[3] = 32'h0000_7000;
        m = '{32'h0, 32'h0, 1'b0, 1'b0, 5'd0};

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");
        @(negedge clk);
        reset = 1'b0;

        step(0, 0, 32'h0000_3040, 32'h1000_0001);
        step(0, 0, 32'h0000_3044, 32'h2402_0007);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("reset_async");
        @(negedge clk);
        reset = 1'b0;
        m = '{32'h0, 32'h0, 1'b0, 1'b0, 5'd0};

        step(0, 0, 32'h0000_3000, 32'h3C01_1234);
        step(0, 0, 32'h0000_3004, 32'h1022_0003);
        step(0, 0, 32'h0000_3008, 32'h0022_1821);
        step(0, 0, 32'h0000_300C, 32'h0000_0000);
        step(0, 0, 32'h0000_3002, 32'h2402_0001);
        step(0, 0, 32'h0000_7000, 32'h2402_0002);
        step(0, 0, 32'h0000_6FFC, 32'h2402_0003);
        step(0, 0, 32'h0000_3010, 32'h0C00_0C00);
        repeat (3) step(1, 0, 32'h0000_3014, 32'hDEAD_BEEF);
        step(0, 0, 32'h0000_3014, 32'h0022_1821);
        step(1, 1, 32'h0000_3018, 32'h1022_0003);
        step(0, 0, 32'h0000_4200, ERET);
        step(0, 0, 32'h0000_4204, 32'h2402_0009);
        step(0, 0, 32'h0000_3010, 32'h2402_000A);
        step(0, 0, 32'h0000_4200, ERET);
        step(0, 0, 32'h0000_0001, 32'h2402_000B);
        step(0, 0, 32'h0000_4200, ERET);
        repeat (2) step(1, 0, 32'h0000_4204, 32'h2402_000C);
        step(0, 0, 32'h0000_4204, 32'h2402_000C);
        step(0, 0, 32'h0000_3020, 32'h2402_000D);
        step(0, 0, 32'h0000_4200, ERET);
        step(0, 1, 32'h0000_4204, 32'h2402_000E);
        step(0, 0, 32'h0000_3024, 32'h2402_000F);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0:       pc = $urandom;
                1:       pc = BASE + ($urandom_range(0, 32'h3FFF) * 4) + $urandom_range(1, 3);
                2:       pc = edges[$urandom_range(0, 3)];
                default: pc = BASE + ($urandom_range(0, 32'h3FFF) * 4);
            endcase
            case ($urandom_range(0, 7))
                0:       ins = ERET;
                1:       ins = {$urandom_range(1, 7), 26'($urandom)};
                2:       ins = {6'd0, 20'($urandom), $urandom_range(8, 9)};
                default: ins = $urandom;
            endcase
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, pc, ins);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
